// File: rtl/core_pipe_pkg.sv
// Shared pipeline payload types and encodings for the RV32I core.
package core_pipe_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [1:0] RESULTSRC_ALU  = 2'b00;
  localparam logic [1:0] RESULTSRC_LOAD = 2'b01;
  localparam logic [1:0] RESULTSRC_PC4  = 2'b10;
  localparam logic [1:0] RESULTSRC_IMM  = 2'b11;

  typedef struct packed {
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic       MemWrite;
    logic       Jump;
    logic       Branch;
    logic [3:0] ALUControl;
    logic       ALUSrc;
    logic       SrcAsrc;
    logic [2:0] funct3;
    logic       jumpReg;
  } ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0]   RD1;
    logic [XLEN-1:0]   RD2;
    logic [XLEN-1:0]   PC;
    logic [XLEN-1:0]   ImmExt;
    logic [XLEN-1:0]   PCPlus4;
    logic [REG_AW-1:0] Rs1;
    logic [REG_AW-1:0] Rs2;
    logic [REG_AW-1:0] Rd;
  } data_t;

  localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/idex_if.sv
// ID/EX bundle carrying registered control and data into the execute stage.
interface idex_if;
  import core_pipe_pkg::*;

  ctrl_t ctrl;
  data_t data;

  modport wr (output ctrl, output data);
  modport rd (input ctrl, input data);
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at its maximum value instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/idex_stage_reg.sv
// ID/EX pipeline register with load-use detection, bubble/flush/hold
// handling and saturating stall/flush counters.
module idex_stage_reg
  import core_pipe_pkg::*;
#(
  parameter int unsigned CNT_W          = 32,
  parameter logic [1:0]  LOAD_RESULTSRC = RESULTSRC_LOAD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  ctrl_t            id_ctrl,
  input  data_t            id_data,
  input  logic             flush_e,
  input  logic             hold_e,
  idex_if.wr               ex,
  output logic             ex_valid,
  output logic             stall_fd,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic lu;
  logic stall_inc;
  logic flush_inc;

  // Load in EX whose destination is a source of the instruction in ID.
  always_comb begin
    lu = ex_valid
       && (ex.ctrl.ResultSrc == LOAD_RESULTSRC)
       && (ex.data.Rd != '0)
       && id_valid
       && ((ex.data.Rd == id_data.Rs1) || (ex.data.Rd == id_data.Rs2));
  end

  assign stall_fd  = (lu && !flush_e) || hold_e;
  assign stall_inc = !hold_e && !flush_e && lu;
  assign flush_inc = !hold_e && flush_e && id_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex.ctrl  <= BUBBLE_CTRL;
      ex.data  <= '0;
      ex_valid <= 1'b0;
    end else if (!hold_e) begin
      if (flush_e || lu) begin
        ex.ctrl  <= BUBBLE_CTRL;
        ex.data  <= '0;
        ex_valid <= 1'b0;
      end else begin
        // An empty slot never carries side-effect controls.
        ex.ctrl  <= id_valid ? id_ctrl : BUBBLE_CTRL;
        ex.data  <= id_data;
        ex_valid <= id_valid;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_idex_stage_reg.sv
// Randomized and directed checks of idex_stage_reg against a behavioural model.
module tb_idex_stage_reg;
  import core_pipe_pkg::*;

  logic  clk;
  logic  in_reset, in_valid, in_flush, in_hold;
  ctrl_t in_ctrl;
  data_t in_data;

  idex_if ex32 ();
  idex_if ex4 ();
  logic        v32, v4, sfd32, sfd4;
  logic [31:0] sc32, fc32;
  logic [3:0]  sc4, fc4;

  idex_stage_reg #(.CNT_W(32)) dut32 (
    .clk(clk), .reset(in_reset), .id_valid(in_valid), .id_ctrl(in_ctrl),
    .id_data(in_data), .flush_e(in_flush), .hold_e(in_hold), .ex(ex32),
    .ex_valid(v32), .stall_fd(sfd32), .stall_cnt(sc32), .flush_cnt(fc32)
  );

  idex_stage_reg #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(in_reset), .id_valid(in_valid), .id_ctrl(in_ctrl),
    .id_data(in_data), .flush_e(in_flush), .hold_e(in_hold), .ex(ex4),
    .ex_valid(v4), .stall_fd(sfd4), .stall_cnt(sc4), .flush_cnt(fc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model state: what EX must hold, plus unbounded event counts.
  bit     m_valid;
  ctrl_t  m_ctrl;
  data_t  m_data;
  longint m_stall, m_flush;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_lu();
    return m_valid && (m_ctrl.ResultSrc == 2'b01) && (m_data.Rd != 5'd0) && in_valid &&
           ((m_data.Rd == in_data.Rs1) || (m_data.Rd == in_data.Rs2));
  endfunction

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_update();
    bit lu_now;
    lu_now = model_lu();
    if (in_reset) begin
      m_valid = 0; m_ctrl = '0; m_data = '0; m_stall = 0; m_flush = 0;
    end else if (!in_hold) begin
      if (in_flush) begin
        m_valid = 0; m_ctrl = '0; m_data = '0;
        if (in_valid) m_flush++;
      end else if (lu_now) begin
        m_valid = 0; m_ctrl = '0; m_data = '0;
        m_stall++;
      end else begin
        m_valid = in_valid;
        m_ctrl  = in_valid ? in_ctrl : '0;
        m_data  = in_data;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ex_valid32", 256'(v32), 256'(m_valid));
      chk("ctrl32", 256'(ex32.ctrl), 256'(m_ctrl));
      chk("data32", 256'(ex32.data), 256'(m_data));
      chk("stall_fd32", 256'(sfd32), 256'(in_hold || (model_lu() && !in_flush)));
      chk("stall_cnt32", 256'(sc32), 256'(sat(m_stall, 32)));
      chk("flush_cnt32", 256'(fc32), 256'(sat(m_flush, 32)));
      chk("ex_valid4", 256'(v4), 256'(m_valid));
      chk("ctrl4", 256'(ex4.ctrl), 256'(m_ctrl));
      chk("data4", 256'(ex4.data), 256'(m_data));
      chk("stall_fd4", 256'(sfd4), 256'(in_hold || (model_lu() && !in_flush)));
      chk("stall_cnt4", 256'(sc4), 256'(sat(m_stall, 4)));
      chk("flush_cnt4", 256'(fc4), 256'(sat(m_flush, 4)));
    end
  end

  task automatic drive(input bit v, input logic [1:0] rsrc, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    in_valid = v;
    in_ctrl  = '0;
    in_ctrl.RegWrite  = 1'b1;
    in_ctrl.ResultSrc = rsrc;
    in_ctrl.ALUSrc    = (rsrc == 2'b01);
    in_data  = '0;
    in_data.RD1 = 32'h1111_0000 + 32'(rd);
    in_data.RD2 = 32'h2222_0000 + 32'(rs2);
    in_data.PC  = 32'h0000_1000 + 32'(rd) * 4;
    in_data.PCPlus4 = in_data.PC + 32'd4;
    in_data.Rd = rd; in_data.Rs1 = rs1; in_data.Rs2 = rs2;
  endtask

  task automatic rand_inputs();
    bit keep_flush;
    keep_flush = in_hold && in_flush;
    in_valid = ($urandom_range(0, 3) != 0);
    in_ctrl  = ctrl_t'(16'($urandom));
    if ($urandom_range(0, 1) == 1) in_ctrl.ResultSrc = 2'b01;
    in_data.RD1 = $urandom; in_data.RD2 = $urandom; in_data.PC = $urandom;
    in_data.ImmExt = $urandom; in_data.PCPlus4 = $urandom;
    in_data.Rd  = 5'($urandom_range(0, 3));
    in_data.Rs1 = 5'($urandom_range(0, 3));
    in_data.Rs2 = 5'($urandom_range(0, 3));
    in_hold  = ($urandom_range(0, 9) == 0);
    in_flush = keep_flush || ($urandom_range(0, 9) == 0);
    in_reset = ($urandom_range(0, 199) == 0);
  endtask

  ctrl_t add_ctrl;
  data_t add_data;

  initial begin
    m_valid = 0; m_ctrl = '0; m_data = '0; m_stall = 0; m_flush = 0;
    in_reset = 1; in_valid = 0; in_ctrl = '0; in_data = '0; in_flush = 0; in_hold = 0;
    step();
    chk_en = 1'b1;
    step();
    in_reset = 0;
    @(negedge clk);
    chk("rst_valid", 256'(v32), 256'(0));
    chk("rst_ctrl", 256'(ex32.ctrl), 256'(0));
    chk("rst_cnt", 256'({sc32, fc32}), 256'(0));

    // Reset while a valid add x5 sits in EX.
    drive(1, 2'b00, 5'd5, 5'd1, 5'd2);
    step();
    @(negedge clk);
    chk("add_in_ex", 256'({v32, ex32.data.Rd, ex32.ctrl.RegWrite}), 256'({1'b1, 5'd5, 1'b1}));
    in_reset = 1; step(); in_reset = 0; in_valid = 0;
    @(negedge clk);
    chk("midrst", 256'({v32, ex32.ctrl.RegWrite, sc32, fc32}), 256'(0));

    // Load-use: lw x6 then add x7,x6,x1.
    drive(1, 2'b01, 5'd6, 5'd2, 5'd0); step();
    drive(1, 2'b00, 5'd7, 5'd6, 5'd1);
    @(negedge clk);
    chk("lu_stall", 256'(sfd32), 256'(1));
    step();
    @(negedge clk);
    chk("lu_bubble", 256'({v32, ex32.data.Rd, sfd32}), 256'(0));
    chk("lu_cnt", 256'(sc32), 256'(1));
    step();
    @(negedge clk);
    chk("lu_add", 256'({v32, ex32.data.Rd}), 256'({1'b1, 5'd7}));

    // Load to x0 never stalls.
    drive(1, 2'b01, 5'd0, 5'd2, 5'd0); step();
    drive(1, 2'b00, 5'd8, 5'd0, 5'd0);
    @(negedge clk);
    chk("x0_nostall", 256'(sfd32), 256'(0));
    step();
    @(negedge clk);
    chk("x0_cnt", 256'({sc32, ex32.data.Rd}), 256'({32'd1, 5'd8}));

    // Flush beats load-use; flush of an empty slot is not counted.
    drive(1, 2'b01, 5'd6, 5'd2, 5'd0); step();
    drive(1, 2'b00, 5'd7, 5'd6, 5'd1); in_flush = 1;
    @(negedge clk);
    chk("flu_stall", 256'(sfd32), 256'(0));
    step(); in_flush = 0;
    @(negedge clk);
    chk("flu_res", 256'({v32, fc32, sc32}), 256'({1'b0, 32'd1, 32'd1}));
    in_valid = 0; in_flush = 1; step(); in_flush = 0;
    @(negedge clk);
    chk("flush_inv", 256'(fc32), 256'(1));

    // Hold with flush pending: EX frozen, then flush lands once hold drops.
    drive(1, 2'b00, 5'd5, 5'd1, 5'd2);
    add_ctrl = in_ctrl; add_data = in_data;
    step();
    drive(1, 2'b01, 5'd9, 5'd5, 5'd5); in_hold = 1; in_flush = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_sfd", 256'(sfd32), 256'(1));
      step();
      @(negedge clk);
      chk("hold_ex", 256'({v32, ex32.ctrl, ex32.data}), 256'({1'b1, add_ctrl, add_data}));
      chk("hold_cnt", 256'({sc32, fc32}), 256'({32'd1, 32'd1}));
    end
    in_hold = 0; step(); in_flush = 0;
    @(negedge clk);
    chk("hold_flush", 256'({v32, fc32}), 256'({1'b0, 32'd2}));

    // Saturation: 20 load-use stalls after reset.
    in_reset = 1; step(); in_reset = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1, 2'b01, 5'd6, 5'd0, 5'd0); step();
      drive(1, 2'b00, 5'd7, 5'd6, 5'd1); step();
    end
    @(negedge clk);
    chk("sat4", 256'(sc4), 256'(15));
    chk("sat32", 256'(sc32), 256'(20));
    drive(1, 2'b01, 5'd6, 5'd0, 5'd0); step();
    drive(1, 2'b00, 5'd7, 5'd6, 5'd1); step();
    @(negedge clk);
    chk("sat4_stay", 256'(sc4), 256'(15));

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      step();
    end
    in_reset = 0; in_hold = 0; in_flush = 0; in_valid = 0;
    step();
    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/idex_stage_reg.md
Name: idex_stage_reg

Overview:
- ID/EX pipeline register for the 5-stage RV32I core.
- Captures decoded control and data from the decode stage and drives the execute stage through idex_if (wr modport).
- Owns the load-use hazard check, so it generates decode/fetch stall requests.
- Handles bubble insertion, branch/jump flush, downstream hold, and saturating performance counters for stalls and flushes.

Parameters:
- CNT_W, 32, width of stall_cnt and flush_cnt.
- LOAD_RESULTSRC, 2'b01, ResultSrc encoding that marks a load in EX.

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous, active-high reset.
- id_valid  input  1  decode stage holds a real instruction.
- id_ctrl  input  ctrl_t  decoded control (RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUControl, ALUSrc, SrcAsrc, funct3, jumpReg).
- id_data  input  data_t  RD1, RD2, PC, ImmExt, PCPlus4, Rs1, Rs2, Rd.
- flush_e  input  1  taken branch/jump resolved in EX; kills the instruction entering EX.
- hold_e  input  1  downstream stall; EX contents must not change.
- ex  interface  idex_if.wr  registered ctrl/data to the execute stage.
- ex_valid  output  1  EX slot holds a real instruction.
- stall_fd  output  1  stall PC and IF/ID register.
- stall_cnt  output  CNT_W  load-use bubbles inserted.
- flush_cnt  output  CNT_W  valid instructions killed by flush_e.

Behaviour:
- Clocking and reset:
  - Single clock domain; all state updates on posedge clk.
  - Reset is synchronous, active-high.
  - On reset: ex.ctrl = all zeros, ex.data = all zeros, ex_valid=0, stall_cnt=0, flush_cnt=0.
  - Reset overrides every other input in the same cycle.
- Load-use detect (combinational):
  - lu = ex_valid & (ex.ctrl.ResultSrc==LOAD_RESULTSRC) & (ex.data.Rd!=0) & id_valid & ((ex.data.Rd==id_data.Rs1) | (ex.data.Rd==id_data.Rs2)).
  - Rs2 is compared even for I-type instructions (conservative; accepted).
- stall_fd = (lu & ~flush_e) | hold_e. Combinational, no register delay.
- Register update priority, highest first:
  1. reset.
  2. hold_e: all EX state holds; counters unchanged; flush_e and lu are ignored this cycle. The requester keeps flush_e asserted until hold_e drops.
  3. flush_e: load a bubble. flush_cnt increments if id_valid=1.
  4. lu: load a bubble. stall_cnt increments.
  5. Otherwise: ex.ctrl<=id_ctrl, ex.data<=id_data, ex_valid<=id_valid.
- Bubble definition:
  - ex.ctrl all zeros, so RegWrite=0, MemWrite=0, Jump=0, Branch=0.
  - ex.data.Rd=0; other data fields are don't-care, and zeros are driven.
  - ex_valid=0.
- Invalid instructions: if id_valid=0 on a normal load, ctrl is also forced to zero. An invalid slot never carries side-effect controls.
- Latency and stall length:
  - One cycle from decode to EX.
  - A load-use stall lasts exactly one cycle. The next cycle EX holds the bubble, so lu deasserts by construction.
- flush_e and lu in the same cycle: flush wins, stall_fd=0, only flush_cnt counts. The dependent instruction is killed anyway.
- Counters: saturate at 2^CNT_W-1 and never wrap.
- Register-file write-back bypass is handled in the register file, not in this block.

Decomposition:
- Move ctrl_t and data_t out of idex_if into a shared package core_pipe_pkg. idex_if and this block both import it.
- core_pipe_pkg also holds the RESULTSRC_* encodings and BUBBLE_CTRL, a zero constant.
- One natural sub-module: sat_counter (parameter W; inputs clk, reset, inc; output count). Instantiate it twice.
- Hazard compare stays inline.

Test Plan:
- Reset mid-stream: assert reset with a valid add x5 in EX -> next cycle ex_valid=0, RegWrite=0, both counters 0.
- Load-use: lw x6 in EX, then add x7,x6,x1 in ID -> stall_fd=1 for exactly one cycle, bubble in EX (ex_valid=0, Rd=0), stall_cnt=1, add enters EX the following cycle.
- Rd=x0 load: lw x0 in EX, ID reads x0 -> no stall, stall_cnt unchanged.
- Flush vs lu: same-cycle flush_e=1 and lu true -> stall_fd=0, bubble, flush_cnt+1, stall_cnt unchanged. With id_valid=0 and flush_e=1 -> flush_cnt unchanged.
- Hold: hold_e=1 for 3 cycles with flush_e=1 -> EX contents identical across all 3 cycles, stall_fd=1, counters frozen. On the cycle after hold_e drops with flush_e still high -> bubble, flush_cnt+1.
- Saturation: CNT_W=4, force 20 load-use stalls -> stall_cnt ends at 15 and stays there.
